vote_booth_arbiter: RTL and testbench



---
 rtl/vote_booth_arbiter_pkg.sv | 18 +
 rtl/vote_booth_arbiter_rr_arb.sv | 31 +++
 rtl/vote_booth_arbiter.sv | 134 +++++++++++++
 tb/tb_vote_booth_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vote_booth_arbiter_pkg.sv
// vote_pkg: session states, candidate index type and saturating increment helper
package vote_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        OPEN   = 2'b01,
        CLOSED = 2'b10
    } vote_state_e;

    typedef logic [1:0] cand_idx_t;

    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
        logic [63:0] mx;
        mx = (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
        return (v >= mx) ? mx : v + 64'd1;
    endfunction

endpackage

// File: rtl/vote_booth_arbiter_rr_arb.sv
// vote_rr_arb: combinational round-robin pick of the first eligible booth at or after the pointer
module vote_rr_arb #(
    parameter int N = 4
) (
    input  logic [N-1:0]         elig_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         pick_o,
    output logic                 any_o
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] idx;
    logic          found;

    // Scan from the pointer with wrap-around and keep only the first hit
    always_comb begin
        pick_o = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((32'(ptr_i) + k) % N);
            if (elig_i[idx] && !found) begin
                pick_o[idx] = 1'b1;
                found       = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/vote_booth_arbiter.sv
// vote_booth_arbiter: session FSM, round-robin ballot grant, lockouts, saturating tallies; VOTE_WINNER_EN adds o_winner/o_tie
module vote_booth_arbiter
    import vote_pkg::*;
#(
    parameter int N_BOOTHS    = 4,
    parameter int N_CAND      = 3,
    parameter int CNT_W       = 32,
    parameter int HOLD_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_open,
    input  logic                    i_voting_over,
    input  logic [N_BOOTHS-1:0]     i_req,
    input  logic [2*N_BOOTHS-1:0]   i_cand,
    output logic [N_BOOTHS-1:0]     o_gnt,
    output logic                    o_reject,
    output logic [N_CAND*CNT_W-1:0] o_tally,
    output logic                    o_result_valid,
`ifdef VOTE_WINNER_EN
    output logic [1:0]              o_winner,
    output logic                    o_tie,
`endif
    output logic [1:0]              o_state
);

    localparam int PW = $clog2(N_BOOTHS);
    localparam int LW = $clog2(HOLD_CYCLES + 1);

    vote_state_e         state_q, state_d;
    logic [CNT_W-1:0]    tally_q [N_CAND];
    logic [CNT_W-1:0]    tally_d [N_CAND];
    logic [LW-1:0]       lock_q  [N_BOOTHS];
    logic [LW-1:0]       lock_d  [N_BOOTHS];
    logic [PW-1:0]       ptr_q, ptr_d, gidx;
    logic [N_BOOTHS-1:0] gnt_q, elig, pick;
    logic                rej_q, any, clear;
    cand_idx_t           cand;

    // State register
    always_ff @(posedge clk) begin
        state_q <= rst ? IDLE : state_d;
    end

    // Session sequencing; the unused encoding falls back to IDLE
    always_comb begin
        case (state_q)
            IDLE:    state_d = i_open ? OPEN : IDLE;
            OPEN:    state_d = i_voting_over ? CLOSED : OPEN;
            CLOSED:  state_d = i_voting_over ? CLOSED : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered results presented to the readout side
    always_comb begin
        o_state        = 2'(state_q);
        o_result_valid = (state_q == CLOSED);
        o_gnt          = gnt_q;
        o_reject       = rej_q;
        for (int c = 0; c < N_CAND; c++) o_tally[CNT_W*c +: CNT_W] = tally_q[c];
    end

    // Eligible booths, granted index and its candidate, session-start clear
    always_comb begin
        for (int b = 0; b < N_BOOTHS; b++)
            elig[b] = (state_q == OPEN) && !i_voting_over && i_req[b] && (lock_q[b] == '0);
        gidx = '0;
        for (int b = 0; b < N_BOOTHS; b++) if (pick[b]) gidx = PW'(b);
        cand  = i_cand[2*gidx +: 2];
        clear = ((state_q == IDLE) && i_open) || (2'(state_q) == 2'b11);
    end

    vote_rr_arb #(.N(N_BOOTHS)) u_arb (
        .elig_i (elig),
        .ptr_i  (ptr_q),
        .pick_o (pick),
        .any_o  (any)
    );

    // Pointer, lockout and tally next values for the grant edge
    always_comb begin
        ptr_d = clear ? '0 : !any ? ptr_q : (gidx == PW'(N_BOOTHS - 1)) ? '0 : gidx + PW'(1);
        for (int b = 0; b < N_BOOTHS; b++)
            lock_d[b] = clear ? '0 : pick[b] ? LW'(HOLD_CYCLES) :
                        (lock_q[b] != '0) ? lock_q[b] - LW'(1) : '0;
        for (int c = 0; c < N_CAND; c++)
            tally_d[c] = clear ? '0 : (any && 32'(cand) == c) ?
                         CNT_W'(sat_inc(64'(tally_q[c]), CNT_W)) : tally_q[c];
    end

    // Datapath registers; reset discards any in-flight grant
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            gnt_q <= '0;
            rej_q <= 1'b0;
            for (int b = 0; b < N_BOOTHS; b++) lock_q[b] <= '0;
            for (int c = 0; c < N_CAND; c++) tally_q[c] <= '0;
        end else begin
            ptr_q <= ptr_d;
            gnt_q <= pick;
            rej_q <= any && (32'(cand) >= N_CAND);
            for (int b = 0; b < N_BOOTHS; b++) lock_q[b] <= lock_d[b];
            for (int c = 0; c < N_CAND; c++) tally_q[c] <= tally_d[c];
        end
    end

`ifdef VOTE_WINNER_EN
    logic [1:0] win_q, win_d, best;
    logic       tie_q, tie_d;
    int         n_max;

    // Capture the leader (lowest index on ties) on entry to CLOSED, hold it there, zero elsewhere
    always_comb begin
        best  = '0;
        n_max = 0;
        for (int c = 1; c < N_CAND; c++) best = (tally_q[c] > tally_q[best]) ? 2'(c) : best;
        for (int c = 0; c < N_CAND; c++) n_max += (tally_q[c] == tally_q[best]) ? 1 : 0;
        win_d = (state_d != CLOSED) ? '0 : (state_q == CLOSED) ? win_q : best;
        tie_d = (state_d != CLOSED) ? 1'b0 : (state_q == CLOSED) ? tie_q : (n_max > 1);
    end

    // Winner registers
    always_ff @(posedge clk) begin
        win_q <= rst ? '0 : win_d;
        tie_q <= rst ? 1'b0 : tie_d;
    end

    assign o_winner = win_q;
    assign o_tie    = tie_q;
`endif

endmodule

// File: tb/tb_vote_booth_arbiter.sv
// tb_vote_booth_arbiter: directed sessions plus random traffic against a per-cycle scoreboard model
module tb_vote_booth_arbiter;

    localparam int NB   = 4;
    localparam int NC   = 3;
    localparam int CW   = 4;
    localparam int HOLD = 16;
    localparam int MAXV = (1 << CW) - 1;

    typedef struct packed {
        logic [NB-1:0]    gnt;
        logic             rej;
        logic [1:0]       st;
        logic             rv;
        logic [NC*CW-1:0] tally;
        logic [1:0]       win;
        logic             tie;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             i_open = 1'b0;
    logic             i_voting_over = 1'b0;
    logic [NB-1:0]    i_req = '0;
    logic [2*NB-1:0]  i_cand = '0;
    logic [NB-1:0]    o_gnt;
    logic             o_reject;
    logic [NC*CW-1:0] o_tally;
    logic             o_result_valid;
    logic [1:0]       o_state;
`ifdef VOTE_WINNER_EN
    logic [1:0]       o_winner;
    logic             o_tie;
`endif

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];

    int          m_state = 0;
    int          m_ptr = 0;
    int          m_win = 0;
    int          m_tie = 0;
    int          m_tally[NC];
    int          m_lock[NB];
    int          drop_mode = 0;
    logic [NB-1:0] late = '0;

    vote_booth_arbiter #(
        .N_BOOTHS(NB), .N_CAND(NC), .CNT_W(CW), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk), .rst(rst), .i_open(i_open), .i_voting_over(i_voting_over),
        .i_req(i_req), .i_cand(i_cand), .o_gnt(o_gnt), .o_reject(o_reject),
        .o_tally(o_tally), .o_result_valid(o_result_valid),
`ifdef VOTE_WINNER_EN
        .o_winner(o_winner), .o_tie(o_tie),
`endif
        .o_state(o_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NC*CW-1:0] pk(input int a, input int b, input int c);
        return {CW'(c), CW'(b), CW'(a)};
    endfunction

    // Reference: what the next clock edge does given the inputs currently driven
    task automatic model_step(output int g);
        exp_t e;
        int   c;
        int   best;
        int   n;
        g = -1;
        c = 0;
        if (rst) begin
            m_state = 0; m_ptr = 0; m_win = 0; m_tie = 0;
            foreach (m_tally[k]) m_tally[k] = 0;
            foreach (m_lock[k]) m_lock[k] = 0;
        end else begin
            if (m_state == 1 && !i_voting_over)
                for (int k = 0; k < NB; k++)
                    if (g < 0 && i_req[(m_ptr + k) % NB] && m_lock[(m_ptr + k) % NB] == 0) g = (m_ptr + k) % NB;
            foreach (m_lock[k]) if (m_lock[k] > 0) m_lock[k]--;
            if (g >= 0) begin
                c = int'(i_cand[2*g +: 2]);
                if (c < NC && m_tally[c] < MAXV) m_tally[c]++;
                m_lock[g] = HOLD;
                m_ptr = (g + 1) % NB;
            end
            case (m_state)
                0: if (i_open) begin
                    m_state = 1; m_ptr = 0;
                    foreach (m_tally[k]) m_tally[k] = 0;
                    foreach (m_lock[k]) m_lock[k] = 0;
                end
                1: if (i_voting_over) begin
                    m_state = 2;
                    best = 0;
                    n = 0;
                    for (int k = 1; k < NC; k++) if (m_tally[k] > m_tally[best]) best = k;
                    for (int k = 0; k < NC; k++) if (m_tally[k] == m_tally[best]) n++;
                    m_win = best;
                    m_tie = (n > 1) ? 1 : 0;
                end
                default: if (!i_voting_over) m_state = 0;
            endcase
            if (m_state != 2) begin m_win = 0; m_tie = 0; end
        end
        e.gnt = (g >= 0) ? NB'(1 << g) : '0;
        e.rej = (g >= 0) && (c >= NC);
        e.st  = 2'(m_state);
        e.rv  = (m_state == 2);
        for (int k = 0; k < NC; k++) e.tally[CW*k +: CW] = CW'(m_tally[k]);
        e.win = 2'(m_win);
        e.tie = m_tie[0];
        q.push_back(e);
    endtask

    // One cycle: predict, advance to the next negedge, then booths react to their grants
    task automatic cyc();
        int g;
        model_step(g);
        @(negedge clk);
        for (int b = 0; b < NB; b++) if (late[b]) begin i_req[b] = 1'b0; late[b] = 1'b0; end
        if (g >= 0 && drop_mode != 2) begin
            if (drop_mode == 1 && $urandom_range(1) == 1) late[g] = 1'b1;
            else i_req[g] = 1'b0;
        end
    endtask

    task automatic vote(input int b, input int c);
        int n;
        n = 0;
        i_cand[2*b +: 2] = 2'(c);
        i_req[b] = 1'b1;
        while (i_req[b] && n < 60) begin cyc(); n++; end
        chk("vote_timeout", {63'd0, i_req[b]}, 64'd0);
        i_req[b] = 1'b0;
    endtask

    task automatic open_session();
        i_open = 1'b1;
        cyc();
        i_open = 1'b0;
    endtask

    task automatic close_session();
        i_voting_over = 1'b1;
        cyc();
        cyc();
        i_voting_over = 1'b0;
        cyc();
    endtask

    // Scoreboard monitor: compare every registered output just after each edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("gnt", o_gnt, e.gnt);
                chk("reject", o_reject, e.rej);
                chk("state", o_state, e.st);
                chk("result_valid", o_result_valid, e.rv);
                chk("tally", o_tally, e.tally);
`ifdef VOTE_WINNER_EN
                chk("winner", o_winner, e.win);
                chk("tie", o_tie, e.tie);
`endif
            end
        end
    end

    initial begin
        int cands[12];
        @(negedge clk);
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        chk("rst_state", o_state, 2'b00);
        chk("rst_tally", o_tally, '0);

        open_session();
        chk("open_state", o_state, 2'b01);
        chk("open_gnt", o_gnt, '0);
        chk("open_tally", o_tally, '0);

        drop_mode = 0;
        i_cand = {2'd1, 2'd2, 2'd1, 2'd0};
        i_req  = 4'b1111;
        cyc();
        chk("rr_b0", o_gnt, 4'b0001);
        cyc();
        chk("rr_b1", o_gnt, 4'b0010);
        cyc();
        chk("rr_b2", o_gnt, 4'b0100);
        cyc();
        chk("rr_b3", o_gnt, 4'b1000);
        cyc();
        chk("rr_tally", o_tally, pk(1, 2, 1));

        vote(1, 3);
        chk("rej_gnt", o_gnt, 4'b0010);
        chk("rej_pulse", o_reject, 1'b1);
        chk("rej_tally", o_tally, pk(1, 2, 1));

        i_cand[5:4] = 2'd2;
        i_req[2] = 1'b1;
        i_voting_over = 1'b1;
        cyc();
        chk("close_nogrant", o_gnt, '0);
        chk("close_rv", o_result_valid, 1'b1);
        repeat (4) cyc();
        chk("frozen_tally", o_tally, pk(1, 2, 1));
        i_voting_over = 1'b0;
        cyc();
        chk("to_idle", o_state, 2'b00);
        chk("retained_tally", o_tally, pk(1, 2, 1));
        i_req = '0;
        cyc();

        open_session();
        drop_mode = 2;
        i_cand[1:0] = 2'd2;
        i_req[0] = 1'b1;
        repeat (40) cyc();
        i_req = '0;
        cyc();
        chk("lockout_tally", o_tally, pk(0, 0, 3));
        close_session();

        open_session();
        i_cand = '0;
        i_req = 4'b1111;
        repeat (80) cyc();
        i_req = '0;
        cyc();
        chk("sat_tally", o_tally, pk(MAXV, 0, 0));
        close_session();

        open_session();
        drop_mode = 0;
        cands = '{0, 1, 0, 1, 2, 0, 1, 0, 1, 2, 0, 1};
        for (int i = 0; i < 12; i++) vote(i % NB, cands[i]);
        chk("win_tally", o_tally, pk(5, 5, 2));
        i_voting_over = 1'b1;
        cyc();
`ifdef VOTE_WINNER_EN
        chk("win_idx", o_winner, 2'd0);
        chk("win_tie", o_tie, 1'b1);
`endif
        cyc();
        i_voting_over = 1'b0;
        cyc();

        drop_mode = 1;
        for (int i = 0; i < 2500; i++) begin
            rst = ($urandom_range(399) == 0);
            i_open = ($urandom_range(7) == 0);
            i_voting_over = i_voting_over ? ($urandom_range(5) != 0) : ($urandom_range(39) == 0);
            for (int b = 0; b < NB; b++)
                if (!i_req[b] && !late[b] && $urandom_range(3) == 0) begin
                    i_cand[2*b +: 2] = 2'($urandom_range(3));
                    i_req[b] = 1'b1;
                end
            cyc();
        end
        rst = 1'b0;
        i_open = 1'b0;
        i_voting_over = 1'b0;
        i_req = '0;
        @(posedge clk);
        #2;
        chk("drain", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
